// File: rtl/bin_pixel_stage.sv
`default_nettype none
// ============================================================================
//  Module   : bin_pixel_stage
//  Purpose  : RGB888 -> luma -> black/white byte stream for the line FIFO,
//             with position counters, overflow and line-length flags.
//  Option   : BIN_HYST_EN adds a per-line hysteresis band around the threshold.
//  Revision : 1.0  initial release
// ============================================================================
module bin_pixel_stage #(
    parameter int H_ACTIVE = 1280,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vs_in,
    input  logic             de_in,
    input  logic [7:0]       r_in,
    input  logic [7:0]       g_in,
    input  logic [7:0]       b_in,
    input  logic [7:0]       thresh,
`ifdef BIN_HYST_EN
    input  logic [7:0]       hyst,
`endif
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_wr_data,
    output logic             vs_out,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_done,
    output logic             ovf_flag,
    output logic             len_err,
    output logic [15:0]      drop_cnt
);

    localparam logic [0:0]       WAIT_VS    = 1'b0;
    localparam logic [0:0]       RUN        = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [31:0]      H_ACTIVE_W = 32'(H_ACTIVE);

    logic [7:0]       red_s1_q, red_s1_d;
    logic [7:0]       grn_s1_q, grn_s1_d;
    logic [7:0]       blu_s1_q, blu_s1_d;
    logic             de_s1_q, de_s1_d, de_s2_q, de_s2_d, de_s3_q, de_s3_d, de_s4_q, de_s4_d;
    logic             vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d, vs_s4_q, vs_s4_d;
    logic [15:0]      sum_q, sum_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       thr_q, thr_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             ovf_q, ovf_d;
    logic             len_err_q, len_err_d;
    logic [15:0]      drop_q, drop_d;

    logic             vs_rise_s1;
    logic             vs_rise_s3;
    logic             run;
    logic             line_end;
    logic             drop;
    logic [7:0]       cmp_thr;
    logic             white;

`ifdef BIN_HYST_EN
    logic [7:0]       hyst_q, hyst_d;
    logic             last_white_q, last_white_d;
    logic [8:0]       thr_sum;
    logic [7:0]       thr_lo;
    logic [7:0]       thr_hi;
`endif

    // Datapath: S1 capture, S2 weighted sum, S3 compare
    always_comb begin
        red_s1_d   = r_in;
        grn_s1_d   = g_in;
        blu_s1_d   = b_in;
        de_s1_d    = de_in;
        de_s2_d    = de_s1_q;
        de_s3_d    = de_s2_q;
        de_s4_d    = de_s3_q;
        vs_s1_d    = vs_in;
        vs_s2_d    = vs_s1_q;
        vs_s3_d    = vs_s2_q;
        vs_s4_d    = vs_s3_q;
        sum_d      = 16'd77  * {8'd0, red_s1_q}
                   + 16'd150 * {8'd0, grn_s1_q}
                   + 16'd29  * {8'd0, blu_s1_q};
        vs_rise_s1 = vs_s1_q & ~vs_s2_q;
        thr_d      = vs_rise_s1 ? thresh : thr_q;
        state_d    = (state_q == WAIT_VS && vs_rise_s1) ? RUN : state_q;
`ifdef BIN_HYST_EN
        hyst_d     = vs_rise_s1 ? hyst : hyst_q;
        thr_lo     = (thr_q > hyst_q) ? (thr_q - hyst_q) : 8'd0;
        thr_sum    = {1'b0, thr_q} + {1'b0, hyst_q};
        thr_hi     = thr_sum[8] ? 8'hFF : thr_sum[7:0];
        cmp_thr    = last_white_q ? thr_lo : thr_hi;
`else
        cmp_thr    = thr_q;
`endif
        // sum[15:8] >= T is equivalent to sum >= T*256
        white      = (sum_q >= {cmp_thr, 8'h00});
        data_d     = white ? 8'hFF : 8'h00;
`ifdef BIN_HYST_EN
        // Tracks the pixel entering S3; any de gap clears it for the next line
        last_white_d = de_s2_q & white;
`endif
    end

    // Frame-gated write, drop accounting and position tracking
    always_comb begin
        run        = (state_q == RUN);
        line_end   = run & de_s4_q & ~de_s3_q;
        vs_rise_s3 = vs_s3_q & ~vs_s4_q;
        drop       = run & de_s3_q & fifo_full;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        ovf_d      = ovf_q;
        len_err_d  = len_err_q;
        drop_d     = drop_q;
        if (run) begin
            if (de_s3_q && pix_x_q != CNT_MAX) begin
                pix_x_d = pix_x_q + CNT_ONE;
            end
            if (line_end) begin
                pix_x_d = '0;
                if (pix_y_q != CNT_MAX) begin
                    pix_y_d = pix_y_q + CNT_ONE;
                end
                if ({{(32-CNT_W){1'b0}}, pix_x_q} != H_ACTIVE_W) begin
                    len_err_d = 1'b1;
                end
            end
            if (vs_rise_s3) begin
                pix_x_d = '0;
                pix_y_d = '0;
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_s1_q  <= '0;
            grn_s1_q  <= '0;
            blu_s1_q  <= '0;
            de_s1_q   <= 1'b0;
            de_s2_q   <= 1'b0;
            de_s3_q   <= 1'b0;
            de_s4_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_s3_q   <= 1'b0;
            vs_s4_q   <= 1'b0;
            sum_q     <= '0;
            data_q    <= '0;
            thr_q     <= '0;
            state_q   <= WAIT_VS;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            ovf_q     <= 1'b0;
            len_err_q <= 1'b0;
            drop_q    <= '0;
`ifdef BIN_HYST_EN
            hyst_q       <= '0;
            last_white_q <= 1'b0;
`endif
        end else begin
            red_s1_q  <= red_s1_d;
            grn_s1_q  <= grn_s1_d;
            blu_s1_q  <= blu_s1_d;
            de_s1_q   <= de_s1_d;
            de_s2_q   <= de_s2_d;
            de_s3_q   <= de_s3_d;
            de_s4_q   <= de_s4_d;
            vs_s1_q   <= vs_s1_d;
            vs_s2_q   <= vs_s2_d;
            vs_s3_q   <= vs_s3_d;
            vs_s4_q   <= vs_s4_d;
            sum_q     <= sum_d;
            data_q    <= data_d;
            thr_q     <= thr_d;
            state_q   <= state_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            ovf_q     <= ovf_d;
            len_err_q <= len_err_d;
            drop_q    <= drop_d;
`ifdef BIN_HYST_EN
            hyst_q       <= hyst_d;
            last_white_q <= last_white_d;
`endif
        end
    end

    assign fifo_wr_en   = run & de_s3_q & ~fifo_full;
    assign fifo_wr_data = data_q;
    assign vs_out       = vs_s3_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign line_done    = line_end;
    assign ovf_flag     = ovf_q;
    assign len_err      = len_err_q;
    assign drop_cnt     = drop_q;

endmodule
`default_nettype wire
